// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, issues sequential imem requests, buffers in-order
// responses for decode, and redirects/squashes on execute-resolved control transfers.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_offset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        flush_out,
   output logic        misalign
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {RESET, RUN, HALT} state_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   state_t        state, state_nxt;
   logic [31:0]   fetch_pc, resp_pc, target;
   logic [CW-1:0] outstanding, occupancy, drop_cnt;
   logic [PW-1:0] head, tail;
   entry_t        entries [DEPTH];
   logic          redirect, accept, drop_rsp, rsp_live, push, pop;

   always_comb begin
      redirect       = (state == RUN) && ex_valid && (ex_offset != 32'h4);
      target         = ex_pc + ex_offset;
      flush_out      = redirect;
      // Budget covers in-flight live requests plus buffered entries, so a push never overflows.
      imem_req_valid = (state == RUN) && !redirect &&
                       (({1'b0, outstanding} + {1'b0, occupancy}) < (CW+1)'(DEPTH));
      imem_req_addr  = fetch_pc;
      accept         = imem_req_valid && imem_req_ready;
      drop_rsp       = imem_rsp_valid && (drop_cnt != '0);
      rsp_live       = imem_rsp_valid && (drop_cnt == '0);
      push           = rsp_live && (state == RUN) && !redirect;
      if_valid       = (occupancy != '0);
      pop            = if_valid && if_ready && !redirect;
      if_pc          = if_valid ? entries[head].pc    : 32'h0;
      if_instr       = if_valid ? entries[head].instr : 32'h0;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RESET:   state_nxt = RUN;
         RUN:     if (redirect && (target[1:0] != 2'b00)) state_nxt = HALT;
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RESET;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         occupancy   <= '0;
         drop_cnt    <= '0;
         head        <= '0;
         tail        <= '0;
         misalign    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (redirect) begin
            // Everything still in flight becomes wrong-path; the response arriving now is one of them.
            fetch_pc    <= target;
            resp_pc     <= target;
            outstanding <= '0;
            occupancy   <= '0;
            head        <= '0;
            tail        <= '0;
            drop_cnt    <= outstanding + drop_cnt - CW'(imem_rsp_valid);
            if (target[1:0] != 2'b00) misalign <= 1'b1;
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(accept) - CW'(rsp_live);
            drop_cnt    <= drop_cnt - CW'(drop_rsp);
            occupancy   <= occupancy + CW'(push) - CW'(pop);
            if (push) begin
               tail    <= tail + 1'b1;
               resp_pc <= resp_pc + 32'd4;
            end
            if (pop) head <= head + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) entries[tail] <= '{pc: resp_pc, instr: imem_rsp_data};
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed stimulus with a queue-based scoreboard checked by a
// monitor at every decode handshake, plus a small in-order latency imem responder.
module tb_fetch_pc_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_offset;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid, if_ready;
   logic [31:0] if_pc, if_instr;
   logic        flush_out, misalign;

   fetch_pc_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_offset(ex_offset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_instr(if_instr), .flush_out(flush_out), .misalign(misalign)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct { logic [31:0] data; int due; } pend_t;

   exp_t        exp_q[$];
   pend_t       pend[$];
   logic [31:0] acc_log[$];
   int          n_chk = 0, n_fail = 0, pops = 0, cyc = 0, lat = 1;
   logic        mem_hold = 1'b0;
   logic [7:0]  tag = 8'h0;
   logic        m_acc, m_rst;
   logic [31:0] m_addr;

   function automatic logic [31:0] word(input logic [31:0] pc, input logic [7:0] t);
      return pc ^ {t, 24'h0};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic expect_run(input logic [31:0] base, input int n, input logic [7:0] t);
      for (int i = 0; i < n; i++) exp_q.push_back('{base + 32'(4*i), word(base + 32'(4*i), t)});
   endtask

   task automatic wait_pops(input int n);
      int c = 0;
      while (pops < n && c < 300) begin step(); c++; end
      check("pop count", 32'(pops), 32'(n));
   endtask

   task automatic check_accepts(input logic [31:0] base, input int first, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = (first + i < acc_log.size()) ? acc_log[first + i] : 32'hxxxx_xxxx;
         check("request addr", a, base + 32'(4*i));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; ex_valid = 1'b0; ex_pc = '0; ex_offset = '0;
      if_ready = 1'b0; imem_req_ready = 1'b0; mem_hold = 1'b0; lat = 1;
      step(); step();
      @(negedge clk);
      check("leftover expected", 32'(exp_q.size()), 32'd0);
      check("rst if_valid", 32'(if_valid), 32'd0);
      check("rst req_valid", 32'(imem_req_valid), 32'd0);
      check("rst req_addr", imem_req_addr, 32'h0);
      check("rst flush", 32'(flush_out), 32'd0);
      check("rst misalign", 32'(misalign), 32'd0);
      check("rst if_pc", if_pc, 32'h0);
      check("rst if_instr", if_instr, 32'h0);
      exp_q.delete(); acc_log.delete(); pops = 0;
      step();
      rst = 1'b0;
   endtask

   // imem responder: acceptance seen at negedge, response driven just after the edge
   always begin
      @(negedge clk);
      m_acc  = imem_req_valid && imem_req_ready;
      m_addr = imem_req_addr;
      m_rst  = rst;
      if (m_acc) acc_log.push_back(m_addr);
      @(posedge clk); #1;
      cyc++;
      if (m_rst) begin
         pend.delete();
         imem_rsp_valid = 1'b0;
      end else begin
         if (m_acc) pend.push_back('{word(m_addr, tag), cyc + lat - 1});
         if (pend.size() != 0 && pend[0].due <= cyc && !mem_hold) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend[0].data;
            void'(pend.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
      end
   end

   // scoreboard monitor: every decode handshake pops one expected entry
   always @(negedge clk) begin
      if (!rst && if_valid && if_ready && !flush_out) begin
         if (exp_q.size() == 0) begin
            check("unexpected if_pc", if_pc, 32'hxxxx_xxxx);
         end else begin
            check("if_pc", if_pc, exp_q[0].pc);
            check("if_instr", if_instr, exp_q[0].instr);
            void'(exp_q.pop_front());
         end
         pops++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;

      // 1: streaming fetch, latency 1
      do_reset();
      tag = 8'h01; imem_req_ready = 1'b1; if_ready = 1'b1;
      expect_run(32'h0, 16, tag);
      wait_pops(16);
      if_ready = 1'b0;
      check_accepts(32'h0, 0, 16);

      // 2: decode stalled -> exactly DEPTH requests, then valid drops
      do_reset();
      tag = 8'h02; imem_req_ready = 1'b1;
      repeat (12) step();
      @(negedge clk);
      check("full accepts", 32'(acc_log.size()), 32'd4);
      check("full req_valid", 32'(imem_req_valid), 32'd0);
      step();
      expect_run(32'h0, 8, tag);
      if_ready = 1'b1;
      wait_pops(8);
      if_ready = 1'b0;

      // 3: backward redirect with two outstanding requests
      do_reset();
      tag = 8'h03; mem_hold = 1'b1;
      step(); step();
      imem_req_ready = 1'b1;
      step(); step();
      imem_req_ready = 1'b0;
      @(negedge clk);
      check("two accepted", 32'(acc_log.size()), 32'd2);
      step();
      ex_valid = 1'b1; ex_pc = 32'h10; ex_offset = 32'hFFFF_FFF0; tag = 8'h13;
      @(negedge clk);
      check("t3 flush", 32'(flush_out), 32'd1);
      check("t3 req_valid in redirect", 32'(imem_req_valid), 32'd0);
      step();
      ex_valid = 1'b0; mem_hold = 1'b0; imem_req_ready = 1'b1;
      @(negedge clk);
      check("t3 new addr", imem_req_addr, 32'h0);
      check("t3 new valid", 32'(imem_req_valid), 32'd1);
      check("t3 buffer empty", 32'(if_valid), 32'd0);
      check("t3 no flush after", 32'(flush_out), 32'd0);
      step();
      expect_run(32'h0, 4, tag);
      if_ready = 1'b1;
      wait_pops(4);
      if_ready = 1'b0;
      check_accepts(32'h0, 2, 4);

      // 4: fall-through resolution changes nothing
      do_reset();
      tag = 8'h04; imem_req_ready = 1'b1; if_ready = 1'b1;
      expect_run(32'h0, 8, tag);
      repeat (3) step();
      ex_valid = 1'b1; ex_pc = 32'h4; ex_offset = 32'h4;
      @(negedge clk);
      check("t4 no flush", 32'(flush_out), 32'd0);
      step();
      ex_valid = 1'b0;
      wait_pops(8);
      if_ready = 1'b0;
      check_accepts(32'h0, 0, 8);

      // 5: misaligned redirect halts fetch until reset
      do_reset();
      tag = 8'h05; imem_req_ready = 1'b1;
      repeat (10) step();
      ex_valid = 1'b1; ex_pc = 32'h100; ex_offset = 32'h2;
      @(negedge clk);
      check("t5 flush", 32'(flush_out), 32'd1);
      step();
      ex_valid = 1'b0;
      @(negedge clk);
      check("t5 misalign", 32'(misalign), 32'd1);
      check("t5 if_valid", 32'(if_valid), 32'd0);
      check("t5 req_valid", 32'(imem_req_valid), 32'd0);
      check("t5 accepts before halt", 32'(acc_log.size()), 32'd4);
      step();
      ex_valid = 1'b1; ex_pc = 32'h0; ex_offset = 32'h8;
      @(negedge clk);
      check("t5 halt ignores ex", 32'(flush_out), 32'd0);
      step();
      ex_valid = 1'b0;
      repeat (5) step();
      @(negedge clk);
      check("t5 no accepts in halt", 32'(acc_log.size()), 32'd4);
      check("t5 misalign sticky", 32'(misalign), 32'd1);
      do_reset();
      tag = 8'h15; imem_req_ready = 1'b1; if_ready = 1'b1;
      expect_run(32'h0, 4, tag);
      wait_pops(4);
      if_ready = 1'b0;
      check_accepts(32'h0, 0, 1);

      // 6: request stalled 3 cycles, then redirect in the cycle a response lands
      do_reset();
      tag = 8'h06; lat = 4;
      step();
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6 held addr", imem_req_addr, 32'h4);
         check("t6 held valid", 32'(imem_req_valid), 32'd1);
         step();
      end
      ex_valid = 1'b1; ex_pc = 32'h40; ex_offset = 32'h20; tag = 8'h16;
      @(negedge clk);
      check("t6 flush", 32'(flush_out), 32'd1);
      check("t6 req_valid in redirect", 32'(imem_req_valid), 32'd0);
      step();
      ex_valid = 1'b0; imem_req_ready = 1'b1;
      @(negedge clk);
      check("t6 target addr", imem_req_addr, 32'h60);
      check("t6 target valid", 32'(imem_req_valid), 32'd1);
      check("t6 response dropped", 32'(if_valid), 32'd0);
      step();
      expect_run(32'h60, 2, tag);
      if_ready = 1'b1;
      wait_pops(2);
      if_ready = 1'b0;
      check_accepts(32'h60, 1, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
